// File: rtl/fft_pkg.sv
// Shared fp16 arithmetic, complex type and FSM states for the FFT/IFFT pair.
package fft_pkg;

    localparam int unsigned Fp16ExpW   = 5;
    localparam int unsigned Fp16ManW   = 10;
    localparam int          Fp16Bias   = 15;
    localparam int          Fp16ExpMax = 30;
    localparam logic [15:0] Fp16Sat    = 16'h7BFF;
    localparam logic [15:0] Fp16Zero   = 16'h0000;

    typedef struct packed {
        logic [15:0] re;
        logic [15:0] im;
    } cplx_t;

    typedef enum logic [1:0] {LOAD, CALC, UNLOAD} state_e;

    function automatic logic [Fp16ExpW-1:0] fp16_exp(input logic [15:0] x);
        return x[14:10];
    endfunction

    function automatic logic [Fp16ManW-1:0] fp16_man(input logic [15:0] x);
        return x[9:0];
    endfunction

    // Final packing: flush underflow to +0, saturate overflow to the largest finite value.
    function automatic logic [15:0] fp16_pack(input logic s, input int e,
                                              input logic [Fp16ManW-1:0] m);
        if (e <= 0) return Fp16Zero;
        if (e > Fp16ExpMax) return {s, Fp16Sat[14:0]};
        return {s, 5'(e), m};
    endfunction

    function automatic logic [15:0] fp16_mul(input logic [15:0] a, input logic [15:0] b);
        logic [21:0] ma;
        logic [21:0] mb;
        logic [21:0] p;
        int          e;
        if (fp16_exp(a) == '0 || fp16_exp(b) == '0) return Fp16Zero;
        ma = {11'd0, 1'b1, fp16_man(a)};
        mb = {11'd0, 1'b1, fp16_man(b)};
        p  = ma * mb;
        e  = int'(fp16_exp(a)) + int'(fp16_exp(b)) - Fp16Bias;
        if (p[21]) return fp16_pack(a[15] ^ b[15], e + 1, p[20:11]);
        return fp16_pack(a[15] ^ b[15], e, p[19:10]);
    endfunction

    // Aligned add with three guard bits; the result is truncated toward zero.
    function automatic logic [15:0] fp16_add(input logic [15:0] a, input logic [15:0] b);
        logic [15:0] x;
        logic [15:0] y;
        logic [13:0] mx;
        logic [13:0] my;
        logic [14:0] r;
        int          e;
        int          d;
        if (fp16_exp(a) == '0 && fp16_exp(b) == '0) return Fp16Zero;
        if (fp16_exp(a) == '0) return b;
        if (fp16_exp(b) == '0) return a;
        if (a[14:0] >= b[14:0]) begin
            x = a;
            y = b;
        end else begin
            x = b;
            y = a;
        end
        d  = int'(fp16_exp(x)) - int'(fp16_exp(y));
        e  = int'(fp16_exp(x));
        mx = {1'b1, fp16_man(x), 3'b000};
        my = (d > 13) ? '0 : ({1'b1, fp16_man(y), 3'b000} >> d);
        if (x[15] == y[15]) r = {1'b0, mx} + {1'b0, my};
        else                r = {1'b0, mx} - {1'b0, my};
        if (r == '0) return Fp16Zero;
        if (r[14]) begin
            r = r >> 1;
            e = e + 1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!r[13]) begin
                    r = r << 1;
                    e = e - 1;
                end
            end
        end
        return fp16_pack(x[15], e, r[12:3]);
    endfunction

    function automatic logic [15:0] fp16_sub(input logic [15:0] a, input logic [15:0] b);
        return fp16_add(a, {~b[15], b[14:0]});
    endfunction

    // Reverse the low 'bits' bits of k.
    function automatic logic [4:0] bitrev(input logic [4:0] k, input int unsigned bits);
        logic [4:0] r;
        for (int i = 0; i < 5; i++) r[i] = k[4-i];
        return r >> (5 - bits);
    endfunction

endpackage

// File: rtl/ifft_butterfly.sv
// Combinational radix-2 butterfly: sum = a + b*w, diff = a - b*w.
module ifft_butterfly
    import fft_pkg::*;
(
    input  cplx_t a,
    input  cplx_t b,
    input  cplx_t w,
    output cplx_t sum,
    output cplx_t diff
);

    cplx_t t;

    // Complex product then add/subtract against the upper leg
    always_comb begin
        t.re    = fp16_sub(fp16_mul(b.re, w.re), fp16_mul(b.im, w.im));
        t.im    = fp16_add(fp16_mul(b.re, w.im), fp16_mul(b.im, w.re));
        sum.re  = fp16_add(a.re, t.re);
        sum.im  = fp16_add(a.im, t.im);
        diff.re = fp16_sub(a.re, t.re);
        diff.im = fp16_sub(a.im, t.im);
    end

endmodule

// File: rtl/ifft_core.sv
// Iterative in-place radix-2 DIT inverse FFT with 1/N output scaling.
module ifft_core
    import fft_pkg::*;
#(
    parameter int unsigned N       = 8,
    parameter int unsigned LOG2N   = 3,
    parameter              TW_FILE = "Twiddle_values_8bit.mem"
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        busy
);

    localparam int unsigned IdxW      = LOG2N;
    localparam int unsigned BflyW     = LOG2N - 1;
    localparam logic [IdxW-1:0] LastIdx = IdxW'(N - 1);
    localparam logic [2:0] LastStage  = 3'(LOG2N - 1);

    // TW_FILE names the forward table that tw_rom reproduces; it must stay set.
    if (N != (32'd1 << LOG2N) || N < 8 || N > 32 || $bits(TW_FILE) < 8) begin : g_bad_cfg
        $error("ifft_core: N must be 8, 16 or 32, LOG2N = log2(N), TW_FILE non-empty");
    end

    // cos(2*pi*m/32) for m = 0..8, fp16 truncated
    function automatic logic [15:0] qcos(input logic [3:0] m);
        logic [15:0] v;
        case (m)
            4'd0:    v = 16'h3C00;
            4'd1:    v = 16'h3BD8;
            4'd2:    v = 16'h3B64;
            4'd3:    v = 16'h3AA6;
            4'd4:    v = 16'h39A8;
            4'd5:    v = 16'h3871;
            4'd6:    v = 16'h361F;
            4'd7:    v = 16'h323E;
            default: v = Fp16Zero;
        endcase
        return v;
    endfunction

    // Forward twiddle W^k of a 32-point transform, k = 0..15
    function automatic cplx_t tw_rom(input logic [3:0] k);
        cplx_t       w;
        logic [15:0] c;
        logic [15:0] s;
        if (k <= 4'd8) begin
            w.re = qcos(k);
            s    = qcos(4'd8 - k);
        end else begin
            c    = qcos(4'd0 - k);
            w.re = c | 16'h8000;
            s    = qcos(k - 4'd8);
        end
        w.im = (s == Fp16Zero) ? Fp16Zero : (s | 16'h8000);
        return w;
    endfunction

    // Divide by N via the exponent; anything that would go subnormal becomes zero.
    function automatic logic [15:0] scale(input logic [15:0] x);
        if (fp16_exp(x) <= 5'(LOG2N)) return Fp16Zero;
        return {x[15], fp16_exp(x) - 5'(LOG2N), fp16_man(x)};
    endfunction

    state_e          state_q, state_d;
    logic [IdxW-1:0] cnt_q;
    logic [2:0]      stage_q;
    logic [BflyW-1:0] bfly_q;
    logic [IdxW:0]   rd_q;
    logic            out_valid_q;
    cplx_t           out_data_q;
    cplx_t           mem_q [N];

    logic [IdxW-1:0] j, span, pos, a_idx, b_idx, ld_idx;
    logic [3:0]      tw_k;
    cplx_t           tw_raw, tw, bf_sum, bf_diff;

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != LOAD);
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

    // Butterfly addressing, twiddle lookup (conjugated) and bit-reversed load address
    always_comb begin
        j      = IdxW'(bfly_q);
        span   = IdxW'(1) << stage_q;
        pos    = j & (span - IdxW'(1));
        a_idx  = ((j >> stage_q) << (stage_q + 3'd1)) + pos;
        b_idx  = a_idx + span;
        tw_k   = 4'(pos) << (3'd4 - stage_q);
        tw_raw = tw_rom(tw_k);
        tw     = tw_raw;
        tw.im  = (tw_raw.im[14:0] == '0) ? tw_raw.im : {~tw_raw.im[15], tw_raw.im[14:0]};
        ld_idx = IdxW'(bitrev(5'(cnt_q), LOG2N));
    end

    ifft_butterfly u_bfly (
        .a    (mem_q[a_idx]),
        .b    (mem_q[b_idx]),
        .w    (tw),
        .sum  (bf_sum),
        .diff (bf_diff)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= LOAD;
        else        state_q <= state_d;
    end

    // Next-state: frame loaded, last butterfly done, last output taken
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (in_valid && cnt_q == LastIdx) state_d = CALC;
            CALC:    if (&bfly_q && stage_q == LastStage) state_d = UNLOAD;
            UNLOAD:  if (out_valid_q && out_ready && cnt_q == LastIdx) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    // Sample/transfer counter and butterfly/stage counters; all wrap to 0 at phase end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q   <= '0;
            stage_q <= '0;
            bfly_q  <= '0;
        end else begin
            unique case (state_q)
                LOAD:   if (in_valid) cnt_q <= cnt_q + 1'b1;
                CALC: begin
                    bfly_q <= bfly_q + 1'b1;
                    if (&bfly_q) stage_q <= (stage_q == LastStage) ? 3'd0 : stage_q + 3'd1;
                end
                UNLOAD: if (out_valid_q && out_ready) cnt_q <= cnt_q + 1'b1;
                default: ;
            endcase
        end
    end

    // Sample buffer: bit-reversed loads, then both butterfly legs written together
    always_ff @(posedge clk) begin
        if (state_q == LOAD && in_valid) begin
            mem_q[ld_idx] <= in_data;
        end else if (state_q == CALC) begin
            mem_q[a_idx] <= bf_sum;
            mem_q[b_idx] <= bf_diff;
        end
    end

    // Registered, scaled output stage; refills whenever empty or being drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            rd_q        <= '0;
        end else if (state_q == UNLOAD) begin
            if (!out_valid_q || out_ready) begin
                if (!rd_q[IdxW]) begin
                    out_valid_q   <= 1'b1;
                    out_data_q.re <= scale(mem_q[rd_q[IdxW-1:0]].re);
                    out_data_q.im <= scale(mem_q[rd_q[IdxW-1:0]].im);
                    rd_q          <= rd_q + 1'b1;
                end else begin
                    out_valid_q <= 1'b0;
                end
            end
        end else begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
        end
    end

endmodule
